// File: rtl/count_ctrl_pkg.sv
// Shared types and defaults for the counter run/stop controller.
package count_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10
    } ctrl_state_e;

    localparam int unsigned DefaultDebounceCycles = 4;
    localparam int unsigned DefaultPrescale       = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises and debounces a raw push-button and emits a one-cycle pulse per press.
module button_debounce
    import count_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic press
);

    localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES) + 1;
    // Flip on the edge the counter would reach DEBOUNCE_CYCLES-1, so btn_db follows
    // a clean rise DEBOUNCE_CYCLES edges after the first sampling edge.
    localparam int unsigned FlipAt = (DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0;
    // The sync chain reads low for two edges after reset even with the button held,
    // so arming needs at least three consecutive low samples.
    localparam int unsigned ArmAt  = max_u(DEBOUNCE_CYCLES - 1, 2);
    localparam int unsigned ArmW   = $clog2(ArmAt + 1);

    logic            sync1_q, sync2_q, btn_s;
    logic            btn_db_q, btn_db_d, db_prev_q;
    logic [CntW-1:0] db_cnt_q, db_cnt_d;
    logic [ArmW-1:0] low_cnt_q, low_cnt_d;
    logic            armed_q, armed_d;
    logic            press_q, press_d;

    assign btn_s = sync2_q;

    always_comb begin
        btn_db_d = btn_db_q;
        db_cnt_d = '0;
        if (btn_s != btn_db_q) begin
            if (db_cnt_q == CntW'(FlipAt)) begin
                btn_db_d = btn_s;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // A button held through reset is not a press: only arm once a stable low is seen.
    always_comb begin
        low_cnt_d = '0;
        armed_d   = armed_q;
        if (!btn_s && !btn_db_q) begin
            if (low_cnt_q == ArmW'(ArmAt)) begin
                armed_d = 1'b1;
            end else begin
                low_cnt_d = low_cnt_q + 1'b1;
            end
        end
    end

    assign press_d = armed_q & btn_db_q & ~db_prev_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            btn_db_q  <= 1'b0;
            db_prev_q <= 1'b0;
            db_cnt_q  <= '0;
            low_cnt_q <= '0;
            armed_q   <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            sync1_q   <= button;
            sync2_q   <= sync1_q;
            btn_db_q  <= btn_db_d;
            db_prev_q <= btn_db_q;
            db_cnt_q  <= db_cnt_d;
            low_cnt_q <= low_cnt_d;
            armed_q   <= armed_d;
            press_q   <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/count_enable_ctrl.sv
// Run/pause controller producing a prescaled enable strobe for the 4-bit up counter.
module count_enable_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
    parameter int unsigned PRESCALE        = DefaultPrescale
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    input  logic clear,
    output logic enable,
    output logic running
);

    localparam int unsigned     PreW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);

    logic            press;
    ctrl_state_e     state_q, state_d;
    logic [PreW-1:0] presc_q, presc_d;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock  (clock),
        .reset  (reset),
        .button (button),
        .press  (press)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // clear wins over a coincident press, which is simply lost.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else if (press) begin
            case (state_q)
                StIdle:  state_d = StRun;
                StRun:   state_d = StPause;
                StPause: state_d = StRun;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        running = (state_q == StRun);
        enable  = running && (presc_q == PreLast);
    end

    // Only cycles that stay in RUN advance the phase, so a resume picks up where it left off.
    always_comb begin
        presc_d = presc_q;
        if (PRESCALE == 1) begin
            presc_d = '0;
        end else if (state_q == StIdle && state_d == StRun) begin
            presc_d = '0;
        end else if (state_q == StRun && state_d == StRun) begin
            presc_d = (presc_q == PreLast) ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule
